// File: rtl/clk_div_multi_pkg.sv
// Shared defaults and configuration validity rule for the multi-channel clock divider.
package clk_div_multi_pkg;

  localparam int DEF_WIDTH    = 28;
  localparam int DEF_NCH      = 2;
  localparam int DEF_DIV_VAL  = 20000;
  localparam int DEF_HIGH_VAL = 10000;

  // A configuration is usable when the period has at least two cycles and the
  // high time leaves at least one high and one low cycle in every period.
  function automatic logic cfg_valid(input logic [31:0] div, input logic [31:0] high);
    return (div >= 32'd2) && (high >= 32'd1) && (high < div);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active and shadow configuration, registered outputs.
module clk_div_chan
  import clk_div_multi_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEF_DIV  = DEF_DIV_VAL,
  parameter int DEF_HIGH = DEF_HIGH_VAL
) (
  input  logic             clock_in,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] high_count,
  output logic             clock_out,
  output logic             tick,
  output logic             pending,
  output logic             cfg_err
);

  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_DIV   = WIDTH'(DEF_DIV);
  localparam logic [WIDTH-1:0] RST_HIGH  = WIDTH'(DEF_HIGH);
  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(DEF_DIV - 1);

  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] active_div;
  logic [WIDTH-1:0] active_high;
  logic [WIDTH-1:0] shadow_div;
  logic [WIDTH-1:0] shadow_high;

  logic             load_ok;
  logic             load_bad;
  logic             wrap;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] eff_high;

  // Classify the load strobe and work out the next counter value; on a wrap with a
  // pending config the new high time already governs the first cycle of the period.
  always_comb begin
    load_ok    = load && cfg_valid(32'(divisor), 32'(high_count));
    load_bad   = load && !cfg_valid(32'(divisor), 32'(high_count));
    wrap       = (counter == (active_div - ONE));
    next_count = wrap ? '0 : (counter + ONE);
    eff_high   = (wrap && pending) ? shadow_high : active_high;
  end

  // Counter, configuration double-buffer and registered outputs for this channel.
  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      counter     <= RST_COUNT;
      active_div  <= RST_DIV;
      active_high <= RST_HIGH;
      shadow_div  <= RST_DIV;
      shadow_high <= RST_HIGH;
      clock_out   <= 1'b0;
      tick        <= 1'b0;
      pending     <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      if (enable) begin
        counter   <= next_count;
        clock_out <= (next_count < eff_high);
        tick      <= wrap;
        if (wrap && pending) begin
          active_div  <= shadow_div;
          active_high <= shadow_high;
          pending     <= 1'b0;
        end
        if (load_ok) begin
          shadow_div  <= divisor;
          shadow_high <= high_count;
          pending     <= 1'b1;
        end
      end else begin
        clock_out <= 1'b0;
        tick      <= 1'b0;
        if (load_ok) begin
          active_div  <= divisor;
          active_high <= high_count;
          counter     <= divisor - ONE;
          pending     <= 1'b0;
        end else if (pending) begin
          active_div  <= shadow_div;
          active_high <= shadow_high;
          counter     <= shadow_div - ONE;
          pending     <= 1'b0;
        end else begin
          counter <= active_div - ONE;
        end
      end
      if (load_ok) begin
        cfg_err <= 1'b0;
      end else if (load_bad) begin
        cfg_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: one independent clk_div_chan per channel.
module clk_div_multi
  import clk_div_multi_pkg::*;
#(
  parameter int NCH      = DEF_NCH,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEF_DIV  = DEF_DIV_VAL,
  parameter int DEF_HIGH = DEF_HIGH_VAL
) (
  input  logic                 clock_in,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       enable,
  input  logic [NCH-1:0]       load,
  input  logic [NCH*WIDTH-1:0] divisor,
  input  logic [NCH*WIDTH-1:0] high_count,
  output logic [NCH-1:0]       clock_out,
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       pending,
  output logic [NCH-1:0]       cfg_err
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clk_div_chan #(
      .WIDTH   (WIDTH),
      .DEF_DIV (DEF_DIV),
      .DEF_HIGH(DEF_HIGH)
    ) u_chan (
      .clock_in  (clock_in),
      .rst_n     (rst_n),
      .enable    (enable[i]),
      .load      (load[i]),
      .divisor   (divisor[i*WIDTH +: WIDTH]),
      .high_count(high_count[i*WIDTH +: WIDTH]),
      .clock_out (clock_out[i]),
      .tick      (tick[i]),
      .pending   (pending[i]),
      .cfg_err   (cfg_err[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomised and directed bench for clk_div_multi with a queue-based scoreboard.
module tb_clk_div_multi;
  import clk_div_multi_pkg::*;

  localparam int NCH     = 2;
  localparam int WIDTH   = 8;
  localparam int TB_DIV  = 4;
  localparam int TB_HIGH = 2;

  logic                 clock_in = 1'b0;
  logic                 rst_n;
  logic [NCH-1:0]       enable;
  logic [NCH-1:0]       load;
  logic [NCH*WIDTH-1:0] divisor;
  logic [NCH*WIDTH-1:0] high_count;
  logic [NCH-1:0]       clock_out;
  logic [NCH-1:0]       tick;
  logic [NCH-1:0]       pending;
  logic [NCH-1:0]       cfg_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // expected {clock_out, tick, pending, cfg_err}, two bits each
  logic [7:0] exp_q[$];

  // reference model: position within the current period per channel
  int m_div[NCH];
  int m_high[NCH];
  int m_sdiv[NCH];
  int m_shigh[NCH];
  bit m_pend[NCH];
  bit m_err[NCH];
  bit m_fresh[NCH];
  int m_pos[NCH];

  clk_div_multi #(
    .NCH     (NCH),
    .WIDTH   (WIDTH),
    .DEF_DIV (TB_DIV),
    .DEF_HIGH(TB_HIGH)
  ) dut (
    .clock_in  (clock_in),
    .rst_n     (rst_n),
    .enable    (enable),
    .load      (load),
    .divisor   (divisor),
    .high_count(high_count),
    .clock_out (clock_out),
    .tick      (tick),
    .pending   (pending),
    .cfg_err   (cfg_err)
  );

  // free-running system clock
  always #5 clock_in = ~clock_in;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_div[c]   = TB_DIV;
      m_high[c]  = TB_HIGH;
      m_sdiv[c]  = TB_DIV;
      m_shigh[c] = TB_HIGH;
      m_pend[c]  = 1'b0;
      m_err[c]   = 1'b0;
      m_fresh[c] = 1'b1;
      m_pos[c]   = 0;
    end
  endtask

  // advance the model by one clock edge using the inputs the DUT just sampled
  task automatic model_step();
    logic [1:0] o, t, p, e;
    bit en, ld, ok;
    int d, h;
    for (int c = 0; c < NCH; c++) begin
      en = enable[c];
      ld = load[c];
      d  = int'(divisor[c*WIDTH +: WIDTH]);
      h  = int'(high_count[c*WIDTH +: WIDTH]);
      ok = cfg_valid(32'(d), 32'(h));
      if (en) begin
        if (m_fresh[c] || m_pos[c] == m_div[c] - 1) begin
          if (m_pend[c]) begin
            m_div[c]  = m_sdiv[c];
            m_high[c] = m_shigh[c];
            m_pend[c] = 1'b0;
          end
          m_pos[c]   = 0;
          m_fresh[c] = 1'b0;
        end else begin
          m_pos[c] = m_pos[c] + 1;
        end
        o[c] = (m_pos[c] < m_high[c]);
        t[c] = (m_pos[c] == 0);
        if (ld) begin
          if (ok) begin
            m_sdiv[c]  = d;
            m_shigh[c] = h;
            m_pend[c]  = 1'b1;
            m_err[c]   = 1'b0;
          end else begin
            m_err[c] = 1'b1;
          end
        end
      end else begin
        o[c]       = 1'b0;
        t[c]       = 1'b0;
        m_fresh[c] = 1'b1;
        if (ld && ok) begin
          m_div[c]  = d;
          m_high[c] = h;
          m_pend[c] = 1'b0;
          m_err[c]  = 1'b0;
        end else begin
          if (ld) m_err[c] = 1'b1;
          if (m_pend[c]) begin
            m_div[c]  = m_sdiv[c];
            m_high[c] = m_shigh[c];
            m_pend[c] = 1'b0;
          end
        end
      end
      p[c] = m_pend[c];
      e[c] = m_err[c];
    end
    exp_q.push_back({o, t, p, e});
  endtask

  // run n clock edges; each edge feeds the model and queues the expected response
  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clock_in);
      #1;
      cyc++;
      model_step();
      load = '0;
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] en, input logic [1:0] ld,
                                input int d0, input int h0, input int d1, input int h1);
    enable     = en;
    load       = ld;
    divisor    = {WIDTH'(d1), WIDTH'(d0)};
    high_count = {WIDTH'(h1), WIDTH'(h0)};
    run_cycles(1);
  endtask

  task automatic check_output(input logic [7:0] e);
    logic [3:0] got, want;
    for (int c = 0; c < NCH; c++) begin
      got  = {clock_out[c], tick[c], pending[c], cfg_err[c]};
      want = {e[6+c], e[4+c], e[2+c], e[c]};
      total++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL ch%0d_cycle%0d: got out/tick/pend/err=%b expected %b", c, cyc, got, want);
      end
    end
  endtask

  task automatic check_zero(input string name);
    total++;
    if ({clock_out, tick, pending, cfg_err} !== 8'h00) begin
      bad++;
      $display("[TB] FAIL %s: got out=%b tick=%b pend=%b err=%b expected all zero",
               name, clock_out, tick, pending, cfg_err);
    end
  endtask

  // monitor: pop one expected entry per cycle on the falling edge and compare
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clock_in);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e);
      end
    end
  end

  // stimulus
  initial begin
    rst_n      = 1'b0;
    enable     = '0;
    load       = '0;
    divisor    = '0;
    high_count = '0;
    model_reset();
    #12;
    check_zero("reset_state");
    @(negedge clock_in);
    #1;
    rst_n = 1'b1;

    // both channels free-running on the defaults
    apply_stimulus(2'b11, 2'b00, 0, 0, 0, 0);
    run_cycles(8);

    // ch0 reprogram while running
    apply_stimulus(2'b11, 2'b01, 5, 1, 0, 0);
    run_cycles(12);

    // ch1 invalid loads, then a valid one
    apply_stimulus(2'b11, 2'b10, 0, 0, 1, 1);
    run_cycles(2);
    apply_stimulus(2'b11, 2'b10, 0, 0, 6, 6);
    run_cycles(5);
    apply_stimulus(2'b11, 2'b10, 0, 0, 3, 2);
    run_cycles(8);

    // ch0 disabled, loaded while idle, re-enabled
    apply_stimulus(2'b10, 2'b00, 0, 0, 0, 0);
    run_cycles(2);
    apply_stimulus(2'b10, 2'b01, 6, 3, 0, 0);
    run_cycles(2);
    apply_stimulus(2'b11, 2'b00, 0, 0, 0, 0);
    run_cycles(13);

    // load landing on the wrap edge, then overwritten while pending
    for (int i = 0; i < 20; i++) begin
      if (!m_fresh[0] && m_pos[0] == m_div[0] - 1) break;
      run_cycles(1);
    end
    apply_stimulus(2'b11, 2'b01, 4, 2, 0, 0);
    apply_stimulus(2'b11, 2'b01, 7, 3, 0, 0);
    run_cycles(20);

    // pending disabled channel picks up the shadow on the idle edge
    apply_stimulus(2'b11, 2'b10, 0, 0, 5, 2);
    apply_stimulus(2'b01, 2'b00, 0, 0, 0, 0);
    run_cycles(2);
    apply_stimulus(2'b11, 2'b00, 0, 0, 0, 0);
    run_cycles(12);

    // asynchronous reset mid-period with a pending config
    apply_stimulus(2'b11, 2'b10, 0, 0, 6, 4);
    for (int i = 0; i < 10; i++) begin
      if (m_pos[0] < m_high[0]) break;
      run_cycles(1);
    end
    @(negedge clock_in);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(posedge clock_in);
    #1;
    check_zero("reset_held");
    @(negedge clock_in);
    #1;
    rst_n = 1'b1;
    model_reset();
    apply_stimulus(2'b11, 2'b00, 0, 0, 0, 0);
    run_cycles(10);

    // randomised traffic
    for (int i = 0; i < 300; i++) begin
      logic [1:0] en, ld;
      en[0] = ($urandom_range(0, 7) != 0);
      en[1] = ($urandom_range(0, 7) != 0);
      ld[0] = ($urandom_range(0, 5) == 0);
      ld[1] = ($urandom_range(0, 5) == 0);
      apply_stimulus(en, ld,
                     int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                     int'($urandom_range(0, 12)), int'($urandom_range(0, 12)));
    end

    // every queued expectation must have been consumed
    @(negedge clock_in);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
